// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte sequencer: byte width, default FIFO
// depth and watchdog limit, and the sequencer FSM state encoding.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SEQ_DEPTH_DEF   = 16;
  localparam int SEQ_TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACCEPT = 2'd2,
    RECV   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Byte-level handshake between the sequencer (master) and the synchronized
// SPI controller (slave). Signal names follow the sequencer's view.
interface spi_byte_sequencer_if;
  import spi_pkg::*;

  logic [SPI_BYTE_W-1:0] o_spi_tx;
  logic                  o_spi_tx_valid;
  logic                  i_spi_ready;
  logic [SPI_BYTE_W-1:0] i_spi_rx;
  logic                  i_spi_rx_valid;

  modport master (
    output o_spi_tx, o_spi_tx_valid,
    input  i_spi_ready, i_spi_rx, i_spi_rx_valid
  );

  modport slave (
    input  o_spi_tx, o_spi_tx_valid,
    output i_spi_ready, i_spi_rx, i_spi_rx_valid
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output. Full/empty come
// from a separate occupancy count; pointers wrap naturally (DEPTH is a
// power of two). A flush empties the FIFO and drops any same-cycle write.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_wr, do_rd;

  // Next pointer/count state; flags are precomputed so they come out of flops
  always_comb begin
    do_wr   = i_wr_en && !full_q && !i_flush;
    do_rd   = i_rd_en && !empty_q && !i_flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (i_flush) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + 1'b1;
      if (do_rd) rptr_d = rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  // Control state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents need no reset because the head is masked when empty
  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wptr_q] <= i_wr_data;
  end

  assign o_rd_data = empty_q ? '0 : mem_q[rptr_q];
  assign o_full    = full_q;
  assign o_empty   = empty_q;
  assign o_count   = count_q;

endmodule

// File: rtl/spi_byte_sequencer.sv
// Host-side byte sequencer in front of the synchronized SPI controller.
// Bytes queued in the TX FIFO are issued one at a time over the controller
// handshake; returned bytes are collected in the RX FIFO.
// Optional build macro SPI_BYTE_SEQUENCER_TIMEOUT_EN adds a per-byte watchdog
// that aborts a stuck transfer, flushes the TX FIFO and raises o_timeout.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH          = SEQ_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SPI_BYTE_W-1:0]   i_wr_data,
  input  logic                    i_wr_en,
  output logic                    o_tx_full,
  input  logic                    i_go,
  output logic                    o_busy,
  output logic [SPI_BYTE_W-1:0]   o_rd_data,
  input  logic                    i_rd_en,
  output logic                    o_rx_empty,
  output logic [$clog2(DEPTH):0]  o_rx_count,
  output logic                    o_timeout,
  spi_byte_sequencer_if.master    spi
);

  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t            state_q, state_d;
  logic [SPI_BYTE_W-1:0] spi_tx_q, spi_tx_d;
  logic                  spi_tx_valid_q, spi_tx_valid_d;
  logic                  busy_q, busy_d;

  logic [SPI_BYTE_W-1:0] tx_head;
  logic                  tx_pop, tx_flush, tx_empty, tx_full;
  logic [CW-1:0]         tx_count_unused;
  logic                  rx_push, rx_full, rx_empty;
  logic [CW-1:0]         rx_count;

`ifdef SPI_BYTE_SEQUENCER_TIMEOUT_EN
  localparam int           TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_q, timeout_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  spi_sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (tx_flush),
    .i_wr_data (i_wr_data),
    .i_wr_en   (i_wr_en),
    .i_rd_en   (tx_pop),
    .o_rd_data (tx_head),
    .o_full    (tx_full),
    .o_empty   (tx_empty),
    .o_count   (tx_count_unused)
  );

  spi_sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (1'b0),
    .i_wr_data (spi.i_spi_rx),
    .i_wr_en   (rx_push),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rd_data),
    .o_full    (rx_full),
    .o_empty   (rx_empty),
    .o_count   (rx_count)
  );

  // Sequencer next-state logic: issue a byte only when the RX FIFO has room
  // for its reply, so a returned byte can never be lost
  always_comb begin
    state_d        = state_q;
    spi_tx_d       = spi_tx_q;
    spi_tx_valid_d = spi_tx_valid_q;
    tx_pop         = 1'b0;
    tx_flush       = 1'b0;
    rx_push        = 1'b0;
`ifdef SPI_BYTE_SEQUENCER_TIMEOUT_EN
    tmr_d          = tmr_q;
    timeout_d      = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_go) begin
`ifdef SPI_BYTE_SEQUENCER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          if (!tx_empty) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (spi.i_spi_ready && !rx_full) begin
          tx_pop         = 1'b1;
          spi_tx_d       = tx_head;
          spi_tx_valid_d = 1'b1;
          state_d        = ACCEPT;
`ifdef SPI_BYTE_SEQUENCER_TIMEOUT_EN
          tmr_d          = '0;
`endif
        end
      end
      ACCEPT: begin
        // ready dropping is the controller's acknowledgement of the byte
        if (!spi.i_spi_ready) begin
          spi_tx_valid_d = 1'b0;
          state_d        = RECV;
        end
      end
      RECV: begin
        if (spi.i_spi_rx_valid) begin
          rx_push = 1'b1;
          state_d = tx_empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_BYTE_SEQUENCER_TIMEOUT_EN
    if ((state_q == ACCEPT) || (state_q == RECV)) begin
      tmr_d = tmr_q + 1'b1;
      if (tmr_q == TMR_LAST) begin
        timeout_d      = 1'b1;
        spi_tx_valid_d = 1'b0;
        tx_flush       = 1'b1;
        rx_push        = 1'b0;
        state_d        = IDLE;
      end
    end
`endif
    busy_d = (state_d != IDLE);
  end

  // Sequencer registers; o_spi_tx is reset too so the controller sees a clean zero
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      spi_tx_q       <= '0;
      spi_tx_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      spi_tx_q       <= spi_tx_d;
      spi_tx_valid_q <= spi_tx_valid_d;
      busy_q         <= busy_d;
    end
  end

`ifdef SPI_BYTE_SEQUENCER_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign spi.o_spi_tx       = spi_tx_q;
  assign spi.o_spi_tx_valid = spi_tx_valid_q;
  assign o_busy             = busy_q;
  assign o_tx_full          = tx_full;
  assign o_rx_empty         = rx_empty;
  assign o_rx_count         = rx_count;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a loopback controller model and
// an expected-byte scoreboard. Define SPI_BYTE_SEQUENCER_TIMEOUT_EN to also
// exercise the watchdog.
module tb_spi_byte_sequencer;
  import spi_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          go = 1'b0;
  logic          rd_en = 1'b0;
  logic          tx_full, busy, rx_empty, timeout;
  logic [7:0]    rd_data;
  logic [CW-1:0] rx_count;

  spi_byte_sequencer_if sif();

  int         vecs = 0;
  int         errs = 0;
  logic [7:0] exp_q[$];

  int         m_st = 0;
  int         m_cnt = 0;
  int         m_rx_cnt = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_hold = 1'b0;
  bit         m_never = 1'b0;

  always #5 clk = ~clk;

  spi_byte_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_data  (wr_data),
    .i_wr_en    (wr_en),
    .o_tx_full  (tx_full),
    .i_go       (go),
    .o_busy     (busy),
    .o_rd_data  (rd_data),
    .i_rd_en    (rd_en),
    .o_rx_empty (rx_empty),
    .o_rx_count (rx_count),
    .o_timeout  (timeout),
    .spi        (sif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: accepts after 3 cycles, returns the same byte 4 cycles later
  always @(negedge clk) begin
    if (!rst_n) begin
      sif.i_spi_ready    = 1'b1;
      sif.i_spi_rx_valid = 1'b0;
      sif.i_spi_rx       = 8'h00;
      m_st  = 0;
      m_cnt = 0;
    end else begin
      case (m_st)
        0: begin
          sif.i_spi_rx_valid = 1'b0;
          if (sif.o_spi_tx_valid) begin
            m_byte = sif.o_spi_tx;
            m_cnt  = 0;
            m_st   = 1;
          end else begin
            sif.i_spi_ready = !m_hold;
          end
        end
        1: begin
          if (sif.o_spi_tx_valid) chk("tx_hold_accept", sif.o_spi_tx, m_byte);
          if (m_never) begin
            if (!sif.o_spi_tx_valid) m_st = 0;
          end else begin
            m_cnt++;
            if (m_cnt == 3) begin
              sif.i_spi_ready = 1'b0;
              m_cnt = 0;
              m_st  = 2;
            end
          end
        end
        2: begin
          chk("tx_hold_recv", sif.o_spi_tx, m_byte);
          chk("valid_low_recv", sif.o_spi_tx_valid, 0);
          m_cnt++;
          if (m_cnt == 4) begin
            sif.i_spi_rx       = m_byte;
            sif.i_spi_rx_valid = 1'b1;
            m_rx_cnt++;
            m_st = 3;
          end
        end
        default: begin
          sif.i_spi_rx_valid = 1'b0;
          sif.i_spi_ready    = 1'b1;
          m_st = 0;
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    if (keep) exp_q.push_back(b);
  endtask

  task automatic pulse_go;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    chk({tag, "_nonempty"}, rx_empty, 0);
    chk(tag, rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int i = 0;
    while (busy && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int i = 0;
    while (!sif.o_spi_tx_valid && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(tag, sif.o_spi_tx_valid, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx_valid"}, sif.o_spi_tx_valid, 0);
    chk({tag, "_spi_tx"}, sif.o_spi_tx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_full"}, tx_full, 0);
    chk({tag, "_rx_empty"}, rx_empty, 1);
    chk({tag, "_rx_count"}, rx_count, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    int start;
    int viol;
    tick(3);
    chk_reset_state("por");
    rst_n = 1'b1;
    tick(1);

    // Three-byte burst in loopback
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    push(8'hFF, 1'b1);
    start = m_rx_cnt;
    pulse_go;
    chk("busy_rise", busy, 1);
    wait_idle(200, "burst_done");
    chk("burst_rx_pulses", m_rx_cnt - start, 3);
    chk("burst_rx_count", rx_count, 3);
    pop_chk("burst_b0");
    pop_chk("burst_b1");
    pop_chk("burst_b2");
    chk("burst_rx_empty", rx_empty, 1);

    // Controller not ready: no valid may appear
    m_hold = 1'b1;
    tick(1);
    push(8'h5A, 1'b1);
    pulse_go;
    viol = 0;
    repeat (20) begin
      if (sif.o_spi_tx_valid) viol++;
      tick(1);
    end
    chk("hs_stall_valid", viol, 0);
    chk("hs_stall_busy", busy, 1);
    m_hold = 1'b0;
    wait_valid(10, "hs_release_valid");
    chk("hs_release_data", sif.o_spi_tx, 8'h5A);
    wait_idle(100, "hs_done");
    pop_chk("hs_b0");

    // RX backpressure: fill RX completely, then one more byte must stall
    for (int i = 0; i < DEPTH; i++) push(8'(i * 17 + 3), 1'b1);
    pulse_go;
    wait_idle(800, "bp_fill_done");
    chk("bp_rx_count_full", rx_count, DEPTH);
    push(8'hC3, 1'b1);
    pulse_go;
    tick(30);
    chk("bp_stall_busy", busy, 1);
    chk("bp_stall_valid", sif.o_spi_tx_valid, 0);
    chk("bp_stall_count", rx_count, DEPTH);
    pop_chk("bp_pop0");
    wait_valid(10, "bp_issue_valid");
    chk("bp_issue_data", sif.o_spi_tx, 8'hC3);
    wait_idle(100, "bp_done");
    chk("bp_rx_count_after", rx_count, DEPTH);
    for (int i = 0; i < DEPTH; i++) pop_chk("bp_drain");
    chk("bp_rx_empty", rx_empty, 1);

    // TX FIFO bounds: DEPTH+1 pushes, the last is dropped
    for (int i = 0; i <= DEPTH; i++) begin
      push(8'(8'h40 + i), (i < DEPTH));
      if (i == DEPTH - 2) chk("bnd_not_full", tx_full, 0);
      if (i == DEPTH - 1) chk("bnd_full", tx_full, 1);
      if (i == DEPTH)     chk("bnd_still_full", tx_full, 1);
    end
    pulse_go;
    wait_idle(800, "bnd_drain_done");
    chk("bnd_rx_count", rx_count, DEPTH);
    for (int i = 0; i < DEPTH; i++) pop_chk("bnd_pop");
    chk("bnd_rx_empty", rx_empty, 1);
    pulse_go;
    chk("go_empty_busy", busy, 0);
    tick(3);
    chk("go_empty_busy_later", busy, 0);
    chk("go_empty_valid", sif.o_spi_tx_valid, 0);

`ifdef SPI_BYTE_SEQUENCER_TIMEOUT_EN
    // Controller never acknowledges: watchdog aborts and flushes
    m_never = 1'b1;
    tick(1);
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    pulse_go;
    wait_valid(10, "tmo_valid");
    begin
      int i = 0;
      while (!timeout && i < TMO) begin
        @(negedge clk);
        i++;
      end
    end
    chk("tmo_flag", timeout, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_valid_low", sif.o_spi_tx_valid, 0);
    chk("tmo_rx_count", rx_count, 0);
    m_never = 1'b0;
    tick(2);
    chk("tmo_sticky", timeout, 1);
    pulse_go;
    chk("tmo_flushed_busy", busy, 0);
    chk("tmo_cleared", timeout, 0);
`else
    chk("tmo_tied_low", timeout, 0);
`endif

    // Reset in the middle of ACCEPT
    m_never = 1'b1;
    tick(1);
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    pulse_go;
    wait_valid(10, "rst_mid_valid");
    tick(2);
    chk("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    tick(2);
    chk_reset_state("rst_mid");
    rst_n = 1'b1;
    m_never = 1'b0;
    tick(2);
    pulse_go;
    chk("rst_mid_tx_emptied", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "time limit");
  end

endmodule
